// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and a long-latency functional unit (mul/div). Pipeline writes win;
//   long-latency results wait in a small FIFO and drain into idle port slots.
//   A starvation counter forces one DRAIN cycle that stalls the pipeline.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pipeWE/pipeRd/pipeData   pipeline writeback request
//   llValid/llRd/llData      long-latency result, accepted when llReady=1
//   llReady                  FIFO has room (based on registered occupancy)
//   WEOut/rdOut/dataOut      registered register-file write
//   pipeStallOut             registered; holds MM/writeback this cycle
//   fifoCount                current FIFO occupancy
module wb_port_arbiter #(
  parameter int width       = 32,
  parameter int rsWidth     = 5,
  parameter int fifoDepth   = 2,
  parameter int starveLimit = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipeWE,
  input  logic [rsWidth-1:0]           pipeRd,
  input  logic [width-1:0]             pipeData,
  input  logic                         llValid,
  input  logic [rsWidth-1:0]           llRd,
  input  logic [width-1:0]             llData,
  output logic                         llReady,
  output logic                         WEOut,
  output logic [rsWidth-1:0]           rdOut,
  output logic [width-1:0]             dataOut,
  output logic                         pipeStallOut,
  output logic [$clog2(fifoDepth):0]   fifoCount
);

  localparam int PW = $clog2(fifoDepth);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(starveLimit + 1);

  typedef enum logic {S_PIPE, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [rsWidth-1:0]   rd_q, rd_d;
  logic [width-1:0]     data_q, data_d;
  logic                 stall_q, stall_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rptr_q, wptr_q;
  logic [SW-1:0]        starve_q, starve_d;

  logic [rsWidth-1:0]   mem_rd   [fifoDepth];
  logic [width-1:0]     mem_data [fifoDepth];

  logic                 enq, deq;
  logic                 fifo_empty;
  logic                 ll_live;
  logic                 pipe_live;

  assign fifo_empty = (count_q == '0);
  assign llReady    = (count_q < CW'(fifoDepth));
  // rd==0 requests never reach the port; an rd==0 long-latency result still
  // completes its handshake but is simply dropped.
  assign ll_live    = llValid && llReady && (llRd != '0);
  assign pipe_live  = pipeWE && (pipeRd != '0);

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    rd_d     = '0;
    data_d   = '0;
    stall_d  = 1'b0;
    starve_d = starve_q;
    enq      = 1'b0;
    deq      = 1'b0;

    case (state_q)
      S_PIPE: begin
        if (pipe_live) begin
          we_d   = 1'b1;
          rd_d   = pipeRd;
          data_d = pipeData;
          enq    = ll_live;
        end else if (!fifo_empty) begin
          we_d   = 1'b1;
          rd_d   = mem_rd[rptr_q];
          data_d = mem_data[rptr_q];
          deq    = 1'b1;
          enq    = ll_live;
        end else if (ll_live) begin
          // Empty FIFO and free port: write straight through, no reordering risk.
          we_d   = 1'b1;
          rd_d   = llRd;
          data_d = llData;
        end

        if (fifo_empty || deq) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q + SW'(1);
        end

        if (starve_d == SW'(starveLimit)) begin
          state_d = S_DRAIN;
          stall_d = 1'b1;
        end
      end

      S_DRAIN: begin
        // Pipeline is stalled and holding its request; the head owns the port.
        if (!fifo_empty) begin
          we_d   = 1'b1;
          rd_d   = mem_rd[rptr_q];
          data_d = mem_data[rptr_q];
          deq    = 1'b1;
        end
        enq      = ll_live;
        starve_d = '0;
        state_d  = S_PIPE;
      end

      default: state_d = S_PIPE;
    endcase

    count_d = count_q;
    if (enq && !deq) count_d = count_q + CW'(1);
    else if (deq && !enq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_PIPE;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
      count_q  <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      // Power-of-two depth: pointers wrap naturally.
      if (deq) rptr_q <= rptr_q + PW'(1);
      if (enq) wptr_q <= wptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[wptr_q]   <= llRd;
      mem_data[wptr_q] <= llData;
    end
  end

  assign WEOut        = we_q;
  assign rdOut        = rd_q;
  assign dataOut      = data_q;
  assign pipeStallOut = stall_q;
  assign fifoCount    = count_q;

endmodule
